registrador_de_flags: RTL
=========================

Name: registrador_de_flags

Overview:
- Consumer end of the ALU overflow path: registers the per-operation flags N, Z, C, V produced alongside the adder/subtractor result, including the overflow bit from the flag detector.
- Keeps a sticky overflow status.
- When trapping is enabled, raises an overflow exception to the control unit over a 4-phase request/acknowledge handshake, capturing the faulting PC.
- Sits between the ALU/flag detector and the control unit / PC logic.

Parameters:
DATA_WIDTH, 32, width of the ALU result.
PC_WIDTH, 32, width of the PC and EPC.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Alu_Valid  input  1  ALU result and flags valid this cycle.
Result  input  DATA_WIDTH  ALU result; source of N and Z.
Carry_Out  input  1  adder carry-out; source of C.
Overflow  input  1  overflow from the flag detector; source of V.
Pc_In  input  PC_WIDTH  PC of the instruction producing Result.
Trap_Enable  input  1  1 = overflow raises an exception.
Flag_Clear  input  1  clears Flags and Sticky_Overflow.
Exception_Ack  input  1  control-unit acknowledge (4-phase).
Flags  output  4  {N,Z,C,V} of the last accepted operation.
Sticky_Overflow  output  1  set by any accepted overflow; cleared only by Flag_Clear.
Exception_Req  output  1  overflow exception request.
Epc  output  PC_WIDTH  PC captured at the exception.
Busy  output  1  high while not IDLE; Alu_Valid is ignored.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-handshake):
  - Flags=0, Sticky_Overflow=0, Exception_Req=0, Epc=0, Busy=0.
  - State=IDLE.
- States: IDLE, REQ, WAIT_LOW. Busy = (state != IDLE), decoded from registered state.
- Accept = Alu_Valid && state==IDLE.
- On accept, next edge:
  - N = Result[DATA_WIDTH-1].
  - Z = (Result == 0).
  - C = Carry_Out.
  - V = Overflow.
  - Flags latency is 1 cycle.
- Sticky_Overflow:
  - Set on accept with Overflow=1.
  - Flag_Clear clears it.
  - Set wins over clear in the same cycle.
- Flag_Clear in IDLE without accept: Flags <= 0.
- Flag_Clear together with accept: the new Flags are loaded (accept wins).
- Flag_Clear while Busy: clears Sticky_Overflow only; Flags are held.
- IDLE -> REQ on accept with Overflow=1 and Trap_Enable=1, at the same edge:
  - Exception_Req <= 1.
  - Epc <= Pc_In.
  - Flags update.
- Accept with Overflow=1 and Trap_Enable=0: flags update, no exception, stay IDLE.
- REQ:
  - Exception_Req held at 1, Epc held, Alu_Valid ignored, Flags frozen.
  - Exception_Ack=1 -> WAIT_LOW with Exception_Req <= 0.
- WAIT_LOW:
  - Exception_Ack=0 -> IDLE.
  - A new accept is possible in the cycle after the return to IDLE.
- Exception_Ack while in IDLE is ignored.
- Trap_Enable is sampled only at the accept cycle. Changing it while in REQ has no effect.
- Epc is held until the next exception or reset.

Optional Feature:
OVERFLOW_COUNTER_EN
- Defined: adds output Overflow_Count [7:0], reset 0.
  - Increments on every accepted overflow, regardless of Trap_Enable.
  - Saturates at 255.
  - Cleared by Flag_Clear; an increment wins over a clear in the same cycle, giving a value of 1.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then Alu_Valid=1, Result=0, Carry_Out=1, Overflow=0 -> next cycle Flags=4'b0110, Exception_Req=0, Busy=0.
- Trap_Enable=1, Alu_Valid=1, Result=32'h8000_0000, Overflow=1, Pc_In=32'h0000_0040 -> next cycle:
  - Flags=4'b1001, Sticky_Overflow=1, Exception_Req=1, Epc=32'h40, Busy=1.
  - A further Alu_Valid with Result=5 leaves Flags at 4'b1001.
- From REQ: Exception_Ack=1 for 3 cycles, then 0 -> Exception_Req falls 1 cycle after Ack rises; Busy falls 1 cycle after Ack falls; Epc stays 32'h40.
- Trap_Enable=0 with accepted Overflow=1 -> Flags[0]=1, Sticky_Overflow=1, Exception_Req stays 0.
- Flag_Clear=1 with an accepted Overflow=1 in the same cycle -> Sticky_Overflow=1; Flag_Clear alone next cycle -> Flags=0, Sticky_Overflow=0.
- Reset asserted while in REQ -> next cycle Exception_Req=0, Epc=0, Busy=0.
- With OVERFLOW_COUNTER_EN: 300 accepted overflows -> Overflow_Count=255.

Source files
------------

// File: rtl/registrador_de_flags.sv
// ============================================================================
// Module  : registrador_de_flags
// Brief   : ALU flag register with sticky overflow and a 4-phase overflow trap
//           handshake towards the control unit. Optional macro:
//           OVERFLOW_COUNTER_EN adds a saturating accepted-overflow counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module registrador_de_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Alu_Valid,
    input  logic [DATA_WIDTH-1:0] Result,
    input  logic                  Carry_Out,
    input  logic                  Overflow,
    input  logic [PC_WIDTH-1:0]   Pc_In,
    input  logic                  Trap_Enable,
    input  logic                  Flag_Clear,
    input  logic                  Exception_Ack,
    output logic [3:0]            Flags,
    output logic                  Sticky_Overflow,
    output logic                  Exception_Req,
    output logic [PC_WIDTH-1:0]   Epc,
    output logic                  Busy
`ifdef OVERFLOW_COUNTER_EN
    ,
    output logic [7:0]            Overflow_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            flags_q, flags_d;
    logic                  sticky_q, sticky_d;
    logic                  req_q, req_d;
    logic [PC_WIDTH-1:0]   epc_q, epc_d;

    logic                  w_accept;
    logic [3:0]            w_new_flags;

    assign w_accept    = Alu_Valid && (state_q == IDLE);
    assign w_new_flags = {Result[DATA_WIDTH-1], (Result == '0), Carry_Out, Overflow};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            flags_q  <= 4'd0;
            sticky_q <= 1'b0;
            req_q    <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            req_q    <= req_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        sticky_d = sticky_q;
        req_d    = req_q;
        epc_d    = epc_q;

        // Flags move only in IDLE; a new operation takes priority over a clear.
        if (w_accept) begin
            flags_d = w_new_flags;
        end else if (Flag_Clear && (state_q == IDLE)) begin
            flags_d = 4'd0;
        end

        if (w_accept && Overflow) begin
            sticky_d = 1'b1;
        end else if (Flag_Clear) begin
            sticky_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_accept && Overflow && Trap_Enable) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    epc_d   = Pc_In;
                end
            end
            REQ: begin
                if (Exception_Ack) begin
                    state_d = WAIT_LOW;
                    req_d   = 1'b0;
                end
            end
            WAIT_LOW: begin
                if (!Exception_Ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign Flags           = flags_q;
    assign Sticky_Overflow = sticky_q;
    assign Exception_Req   = req_q;
    assign Epc             = epc_q;
    assign Busy            = (state_q != IDLE);

`ifdef OVERFLOW_COUNTER_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        // An increment coinciding with a clear restarts the count at one.
        if (w_accept && Overflow) begin
            if (Flag_Clear) begin
                count_d = 8'd1;
            end else if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (Flag_Clear) begin
            count_d = 8'd0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Overflow_Count = count_q;
`endif

endmodule

`default_nettype wire
